// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode
// constants, pc_sel codes and an opcode classifier used by the FSM.
// The datapath can import this package to stay consistent with the controller.
package multicycle_ctrl_pkg;

  // State encoding; the numeric values are also visible on state_o.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXECUTE = 4'd2,
    ST_MEMORY  = 4'd3,
    ST_WRITEBK = 4'd4,
    ST_CONTROL = 4'd5,
    ST_HALT    = 4'd6,
    ST_TRAP    = 4'd7
  } state_e;

  // Opcode map (5-bit base encoding)
  localparam logic [4:0] OP_ALU_LAST = 5'b01001;  // 00000..01001 are ALU ops
  localparam logic [4:0] OP_LOAD     = 5'b01010;
  localparam logic [4:0] OP_STORE    = 5'b01011;
  localparam logic [4:0] OP_NOP      = 5'b01100;
  localparam logic [4:0] OP_JMP      = 5'b01101;
  localparam logic [4:0] OP_BEQ      = 5'b01110;
  localparam logic [4:0] OP_BNE      = 5'b01111;
  localparam logic [4:0] OP_CALL     = 5'b10000;
  localparam logic [4:0] OP_RET      = 5'b10001;
  localparam logic [4:0] OP_HALT     = 5'b11111;

  // pc_sel codes
  localparam logic [1:0] PC_SEL_NEXT   = 2'b00;  // PC+1
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;  // jump / call target
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;  // branch target
  localparam logic [1:0] PC_SEL_RETURN = 2'b11;  // return address

  localparam int WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_NOP,
    CLS_CTRL,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Opcode is passed zero-extended to 32 bits so the classifier works for
  // any OPCODE_W >= 5.
  function automatic op_class_e classify(input logic [31:0] op);
    op_class_e cls;
    if (op <= 32'(OP_ALU_LAST))        cls = CLS_ALU;
    else if (op == 32'(OP_LOAD))       cls = CLS_LOAD;
    else if (op == 32'(OP_STORE))      cls = CLS_STORE;
    else if (op == 32'(OP_NOP))        cls = CLS_NOP;
    else if (op <= 32'(OP_RET))        cls = CLS_CTRL;   // JMP..RET
    else if (op == 32'(OP_HALT))       cls = CLS_HALT;
    else                               cls = CLS_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// ctrl_wait_timer: memory wait-state counter with timeout compare.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count (asserted when the FSM changes state)
//   waiting    : FSM is in a memory-wait state and mem_ready is low
//   timeout    : count has reached WAIT_MAX while still waiting
module ctrl_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15  // legal range 1..255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] count_reg;

  // Clear wins over increment: the cycle that leaves a wait state (including
  // the timeout cycle itself) must leave the counter at zero for the next
  // wait state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (waiting) begin
      count_reg <= count_reg + WAIT_CNT_W'(1);
    end
  end

  assign timeout = waiting && (count_reg == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle CPU.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode                : IR opcode, stable from DECODE until next FETCH
//   mem_ready             : memory completes the current access this cycle
//   zero_flag             : ALU zero result, used by BEQ/BNE in CONTROL
//   mem_read, mem_write   : memory strobes
//   reg_write, load_IR    : register file / IR write enables
//   pc_enable, pc_sel     : PC update enable and source select
//   ALU_op                : ALU operation (opcode during EXECUTE, else 0)
//   halted, trap, bus_err : sticky status (bus_err = trap caused by timeout)
//   state_o               : debug state code
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int PC_SEL_W = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero_flag,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                load_IR,
  output logic                pc_enable,
  output logic [OPCODE_W-1:0] ALU_op,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                halted,
  output logic                trap,
  output logic                bus_err,
  output logic [3:0]          state_o
);

  state_e    state_reg, state_next;
  logic      bus_err_reg, bus_err_next;
  op_class_e op_class;
  logic      mem_wait;
  logic      wait_timeout;
  logic      timer_clear;
  logic [31:0] opcode_ext;

  assign opcode_ext = 32'(opcode);
  assign op_class   = classify(opcode_ext);

  // Only FETCH and MEMORY wait on memory; MEMORY is only reached by LOAD/STORE.
  assign mem_wait    = ((state_reg == ST_FETCH) || (state_reg == ST_MEMORY)) && !mem_ready;
  // Any state change restarts the counter, which covers entry to FETCH/MEMORY.
  assign timer_clear = (state_next != state_reg);

  ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .waiting (mem_wait),
    .timeout (wait_timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= bus_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      ST_FETCH: begin
        if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_timeout) begin
          state_next   = ST_TRAP;
          bus_err_next = 1'b1;
        end
      end
      ST_DECODE: begin
        case (op_class)
          CLS_HALT:    state_next = ST_HALT;
          CLS_ILLEGAL: state_next = ST_TRAP;
          default:     state_next = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_next = ST_MEMORY;
          CLS_CTRL:            state_next = ST_CONTROL;
          CLS_NOP:             state_next = ST_FETCH;
          default:             state_next = ST_WRITEBK;
        endcase
      end
      ST_MEMORY: begin
        // A ready in the timeout cycle still completes the access normally.
        if (mem_ready) begin
          state_next = (op_class == CLS_LOAD) ? ST_WRITEBK : ST_FETCH;
        end else if (wait_timeout) begin
          state_next   = ST_TRAP;
          bus_err_next = 1'b1;
        end
      end
      ST_WRITEBK: state_next = ST_FETCH;
      ST_CONTROL: state_next = ST_FETCH;
      ST_HALT:    state_next = ST_HALT;
      ST_TRAP:    state_next = ST_TRAP;
      default:    state_next = ST_FETCH;
    endcase
  end

  // Output decode. While reset is asserted the outputs already show the
  // FETCH idle pattern so downstream logic never sees a stale strobe.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    load_IR   = 1'b0;
    pc_enable = 1'b0;
    pc_sel    = PC_SEL_W'(PC_SEL_NEXT);
    ALU_op    = '0;
    halted    = 1'b0;
    trap      = 1'b0;
    if (reset) begin
      mem_read = 1'b1;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            load_IR   = 1'b1;
            pc_enable = 1'b1;
            pc_sel    = PC_SEL_W'(PC_SEL_NEXT);
          end
        end
        ST_EXECUTE: ALU_op = opcode;
        ST_MEMORY: begin
          if (op_class == CLS_LOAD) mem_read  = 1'b1;
          else                      mem_write = 1'b1;
        end
        ST_WRITEBK: reg_write = 1'b1;
        ST_CONTROL: begin
          if ((opcode_ext == 32'(OP_JMP)) || (opcode_ext == 32'(OP_CALL))) begin
            pc_enable = 1'b1;
            pc_sel    = PC_SEL_W'(PC_SEL_JUMP);
          end else if (opcode_ext == 32'(OP_RET)) begin
            pc_enable = 1'b1;
            pc_sel    = PC_SEL_W'(PC_SEL_RETURN);
          end else if (((opcode_ext == 32'(OP_BEQ)) && zero_flag) ||
                       ((opcode_ext == 32'(OP_BNE)) && !zero_flag)) begin
            pc_enable = 1'b1;
            pc_sel    = PC_SEL_W'(PC_SEL_BRANCH);
          end
        end
        ST_HALT: halted = 1'b1;
        ST_TRAP: trap   = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_err = bus_err_reg && !reset;
  assign state_o = reset ? 4'(ST_FETCH) : 4'(state_reg);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each instruction is expanded by a
// transaction-level model into the list of cycles it should take, with the
// mem_ready value to drive and the expected output vector for each cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic       zero_flag = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       mem_read, mem_write, reg_write, load_IR, pc_enable;
  logic [4:0] ALU_op;
  logic [1:0] pc_sel;
  logic       halted, trap, bus_err;
  logic [3:0] state_o;

  multicycle_ctrl #(
    .OPCODE_W (5),
    .PC_SEL_W (2),
    .WAIT_MAX (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .zero_flag (zero_flag),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .load_IR   (load_IR),
    .pc_enable (pc_enable),
    .ALU_op    (ALU_op),
    .pc_sel    (pc_sel),
    .halted    (halted),
    .trap      (trap),
    .bus_err   (bus_err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Observed vector: state, strobes {rd,wr,rw,ir,pe}, pc_sel, ALU_op, {halted,trap,bus_err}
  wire [18:0] obs = {state_o, mem_read, mem_write, reg_write, load_IR, pc_enable,
                     pc_sel, ALU_op, halted, trap, bus_err};

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_RD   = 5'b10000;
  localparam logic [4:0] S_WR   = 5'b01000;
  localparam logic [4:0] S_RW   = 5'b00100;
  localparam logic [4:0] S_IRPE = 5'b00011;
  localparam int WAIT_LIMIT = 15;

  typedef struct packed {
    logic        mr;
    logic        zf;
    logic [4:0]  op;
    logic [18:0] exp;
  } cyc_t;

  cyc_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [18:0] mk(input logic [3:0] st, input logic [4:0] strb,
                                     input logic [1:0] sel, input logic [4:0] alu,
                                     input logic [2:0] stat);
    return {st, strb, sel, alu, stat};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic zf, input logic [4:0] op, input logic [18:0] e);
    cyc_t c;
    c.mr = mr; c.zf = zf; c.op = op; c.exp = e;
    q.push_back(c);
  endtask

  // FETCH with fw wait cycles, then DECODE
  task automatic push_front(input logic [4:0] op, input int fw, input logic zf);
    for (int i = 0; i < fw; i++) push(1'b0, zf, op, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    push(1'b1, zf, op, mk(4'd0, S_RD | S_IRPE, 2'b00, 5'd0, 3'b000));
    push(rbit(), zf, op, mk(4'd1, S_NONE, 2'b00, 5'd0, 3'b000));
  endtask

  // Full legal (non-halt) instruction with given fetch and memory wait counts
  task automatic build(input logic [4:0] op, input int fw, input int mw, input logic zf);
    logic taken;
    push_front(op, fw, zf);
    push(rbit(), zf, op, mk(4'd2, S_NONE, 2'b00, op, 3'b000));
    if (op <= 5'd9) begin
      push(rbit(), zf, op, mk(4'd4, S_RW, 2'b00, 5'd0, 3'b000));
    end else if (op == 5'd10 || op == 5'd11) begin
      for (int i = 0; i < mw; i++)
        push(1'b0, zf, op, mk(4'd3, (op == 5'd10) ? S_RD : S_WR, 2'b00, 5'd0, 3'b000));
      push(1'b1, zf, op, mk(4'd3, (op == 5'd10) ? S_RD : S_WR, 2'b00, 5'd0, 3'b000));
      if (op == 5'd10) push(rbit(), zf, op, mk(4'd4, S_RW, 2'b00, 5'd0, 3'b000));
    end else if (op == 5'd12) begin
      // NOP goes straight back to FETCH
    end else if (op == 5'd13 || op == 5'd16) begin
      push(rbit(), zf, op, mk(4'd5, 5'b00001, 2'b01, 5'd0, 3'b000));
    end else if (op == 5'd17) begin
      push(rbit(), zf, op, mk(4'd5, 5'b00001, 2'b11, 5'd0, 3'b000));
    end else begin
      taken = (op == 5'd14) ? zf : !zf;
      push(rbit(), zf, op, taken ? mk(4'd5, 5'b00001, 2'b10, 5'd0, 3'b000)
                                 : mk(4'd5, S_NONE, 2'b00, 5'd0, 3'b000));
    end
  endtask

  task automatic run_queue(input string name);
    int bad = 0;
    int len = q.size();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      mem_ready = q[i].mr;
      zero_flag = q[i].zf;
      opcode    = q[i].op;
      #1;
      n_cmp++;
      if (obs !== q[i].exp) begin
        n_bad++;
        bad++;
        $display("FAIL %s cycle %0d: got %b required %b", name, i, obs, q[i].exp);
      end
    end
    q.delete();
    $display("txn %-16s cycles=%0d bad=%0d", name, len, bad);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_hold: got %b required %b", obs, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs !== mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required %b", obs, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_release: got %b required %b", obs, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    end
    $display("txn reset            done");
  endtask

  task automatic test_alu();
    do_reset();
    build(5'b00001, 0, 0, 1'b0);
    push(1'b0, 1'b0, 5'b00001, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    run_queue("add");
  endtask

  task automatic test_load_wait();
    do_reset();
    build(5'd10, 0, 3, 1'b0);
    push(1'b0, 1'b0, 5'd10, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    run_queue("load_wait3");
  endtask

  task automatic test_branch();
    do_reset();
    build(5'd14, 0, 0, 1'b0);
    build(5'd15, 0, 0, 1'b0);
    build(5'd14, 1, 0, 1'b1);
    build(5'd15, 0, 0, 1'b1);
    run_queue("beq_bne");
    build(5'd13, 0, 0, 1'b0);
    build(5'd16, 2, 0, 1'b1);
    build(5'd17, 0, 0, 1'b0);
    build(5'd12, 0, 0, 1'b0);
    build(5'd11, 0, 0, 1'b0);
    run_queue("jmp_call_ret");
  endtask

  task automatic test_wait_boundary();
    do_reset();
    build(5'd3, WAIT_LIMIT, 0, 1'b0);
    build(5'd10, 0, WAIT_LIMIT, 1'b0);
    build(5'd11, 0, WAIT_LIMIT, 1'b0);
    run_queue("wait_at_limit");
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    for (int i = 0; i <= WAIT_LIMIT; i++)
      push(1'b0, 1'b0, 5'd0, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    for (int i = 0; i < 4; i++)
      push(rbit(), 1'b0, 5'd0, mk(4'd7, S_NONE, 2'b00, 5'd0, 3'b011));
    run_queue("fetch_timeout");
  endtask

  task automatic test_mem_timeout();
    do_reset();
    push_front(5'd10, 0, 1'b0);
    push(1'b0, 1'b0, 5'd10, mk(4'd2, S_NONE, 2'b00, 5'd10, 3'b000));
    for (int i = 0; i <= WAIT_LIMIT; i++)
      push(1'b0, 1'b0, 5'd10, mk(4'd3, S_RD, 2'b00, 5'd0, 3'b000));
    for (int i = 0; i < 3; i++)
      push(rbit(), 1'b0, 5'd10, mk(4'd7, S_NONE, 2'b00, 5'd0, 3'b011));
    run_queue("mem_timeout");
  endtask

  task automatic test_illegal_halt();
    do_reset();
    push_front(5'b10101, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      push(rbit(), 1'b0, 5'b10101, mk(4'd7, S_NONE, 2'b00, 5'd0, 3'b010));
    run_queue("illegal");
    do_reset();
    push_front(5'b11111, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(rbit(), rbit(), 5'b11111, mk(4'd6, S_NONE, 2'b00, 5'd0, 3'b100));
    run_queue("halt");
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    push_front(5'd11, 0, 1'b0);
    push(1'b0, 1'b0, 5'd11, mk(4'd2, S_NONE, 2'b00, 5'd11, 3'b000));
    push(1'b0, 1'b0, 5'd11, mk(4'd3, S_WR, 2'b00, 5'd0, 3'b000));
    push(1'b0, 1'b0, 5'd11, mk(4'd3, S_WR, 2'b00, 5'd0, 3'b000));
    run_queue("store_pre_reset");
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_mid_store: got %b required %b", obs, mk(4'd0, S_RD, 2'b00, 5'd0, 3'b000));
    end
    $display("txn reset_mid_store  done");
  endtask

  task automatic test_random();
    logic [4:0] op;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 17));
      build(op, $urandom_range(0, 5), $urandom_range(0, 5), rbit());
      run_queue($sformatf("rand%0d_op%0d", k, op));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_wait_boundary();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal_halt();
    test_reset_mid_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 5, meaning opcode width; IR[18:14] at default.
REQ-002 The block SHALL have parameter PC_SEL_W, default 2, meaning pc_sel width.
REQ-003 The block SHALL have parameter WAIT_MAX, default 15, meaning maximum mem_ready wait cycles before a bus-error trap; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port opcode, input, OPCODE_W, current IR opcode, stable from DECODE until FETCH.
REQ-007 The block SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-008 The block SHALL have port zero_flag, input, 1, ALU zero result, valid in CONTROL.
REQ-009 The block SHALL have outputs mem_read, mem_write, reg_write, load_IR and pc_enable, each 1 bit, meaning as their names state.
REQ-010 The block SHALL have output ALU_op, OPCODE_W, ALU operation select.
REQ-011 The block SHALL have output pc_sel, PC_SEL_W: 00 = PC+1, 01 = jump/call, 10 = branch, 11 = return.
REQ-012 The block SHALL have outputs halted and trap, each 1 bit, sticky status; output bus_err, 1, trap cause is timeout (0 = illegal opcode); output state_o, 4, debug state code.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBK=4, CONTROL=5, HALT=6, TRAP=7; all outputs decoded combinationally from state, opcode, mem_ready, zero_flag.
REQ-014 Unlisted outputs SHALL be 0 in every state; ALU_op SHALL be 0 outside EXECUTE.
REQ-015 FETCH: mem_read=1 every cycle; when mem_ready=1, load_IR=1, pc_enable=1, pc_sel=00 in that cycle, next state DECODE; else stay.
REQ-016 DECODE: opcodes 00000-01001 (ALU), 01010 LOAD, 01011 STORE, 01100 NOP, 01101 JMP, 01110 BEQ, 01111 BNE, 10000 CALL, 10001 RET -> EXECUTE; 11111 -> HALT; all others -> TRAP with bus_err=0.
REQ-017 EXECUTE: ALU_op=opcode; next MEMORY for LOAD/STORE, CONTROL for JMP/BEQ/BNE/CALL/RET, FETCH for NOP, WRITEBK otherwise.
REQ-018 MEMORY: mem_read=1 (LOAD) or mem_write=1 (STORE) every cycle until mem_ready=1; then LOAD -> WRITEBK, STORE -> FETCH.
REQ-019 WRITEBK: reg_write=1 for one cycle; next FETCH.
REQ-020 CONTROL, one cycle, next FETCH: JMP/CALL pc_enable=1, pc_sel=01; RET pc_enable=1, pc_sel=11; BEQ with zero_flag=1 or BNE with zero_flag=0 pc_enable=1, pc_sel=10; untaken branch pc_enable=0.
REQ-021 An 8-bit wait counter SHALL clear on entry to FETCH or MEMORY and increment each cycle there with mem_ready=0.
REQ-022 When the counter reaches WAIT_MAX with mem_ready still 0, the next state SHALL be TRAP with bus_err=1; mem_ready=1 in that same cycle completes normally instead.
REQ-023 HALT and TRAP SHALL be absorbing: all strobes 0; halted=1 in HALT, trap=1 in TRAP; exit only by reset.
REQ-024 Latency with zero-wait memory SHALL be ALU 4, LOAD 5, STORE 4, control-flow 4, NOP 3 cycles.

Reset
REQ-025 reset=1 at a rising edge SHALL set state FETCH, counter 0 and bus_err 0, taking priority over every transition, including mid-wait in MEMORY.
REQ-026 During and after reset, outputs SHALL equal FETCH decode: mem_read=1, all other strobes 0, halted=0, trap=0, state_o=0.

Structure
REQ-027 A shared package SHALL hold the state encoding, opcode constants and pc_sel codes, for reuse by the datapath and the bench.
REQ-028 The wait counter with timeout compare SHALL be one sub-module, ctrl_wait_timer.

Verification
REQ-029 ADD 00001, mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 only in cycle 4; ALU_op=00001 in cycle 3.
REQ-030 LOAD, mem_ready low for 3 MEMORY cycles -> mem_read held 4 cycles, then one WRITEBK cycle, then FETCH.
REQ-031 BEQ with zero_flag=0, then BNE with zero_flag=0 -> first CONTROL pc_enable=0; second pc_enable=1, pc_sel=10.
REQ-032 mem_ready stuck 0 in FETCH, WAIT_MAX=15 -> TRAP entered after 16 FETCH cycles; trap=1, bus_err=1.
REQ-033 Opcode 10101 -> TRAP with bus_err=0; opcode 11111 -> HALT, halted=1 held for 20 cycles.
REQ-034 reset pulsed during STORE MEMORY wait -> next cycle state_o=0, mem_write=0, mem_read=1.
